// File: rtl/cpu_types_pkg.sv
// cpu_types_pkg: shared CPU datapath types used by the writeback queue.
package cpu_types_pkg;
   typedef logic [31:0] word_t;
   typedef logic [4:0] regbits_t;
   typedef struct packed {
      regbits_t sel;
      word_t    dat;
   } wb_entry_t;
   localparam int WB_DEPTH_DEFAULT = 4;
endpackage

// File: rtl/wb_fifo.sv
// wb_fifo: in-order wb_entry_t queue accepting up to two pushes per cycle.
// entries[] presents the stored entries oldest-first, starting at the head.
module wb_fifo
   import cpu_types_pkg::*;
#(
   parameter int DEPTH = WB_DEPTH_DEFAULT,
   localparam int AW = $clog2(DEPTH)
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [1:0]            push_n,
   input  wb_entry_t             push0,
   input  wb_entry_t             push1,
   input  logic                  pop,
   output wb_entry_t             head,
   output logic [AW:0]           count,
   output wb_entry_t [DEPTH-1:0] entries
);
   wb_entry_t mem [DEPTH];
   logic [AW:0] wptr, rptr;
   logic [AW-1:0] w0, w1;
   assign w0 = wptr[AW-1:0];
   assign w1 = w0 + AW'(1);
   assign count = wptr - rptr;
   assign head = mem[rptr[AW-1:0]];
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         wptr <= '0;
         rptr <= '0;
      end else begin
         wptr <= wptr + (AW+1)'(push_n);
         rptr <= rptr + (AW+1)'(pop);
      end
   always_ff @(posedge clk) begin
      if (push_n != 2'd0) mem[w0] <= push0;
      if (push_n == 2'd2) mem[w1] <= push1;
   end
   for (genvar i = 0; i < DEPTH; i++) begin : g_view
      assign entries[i] = mem[rptr[AW-1:0] + AW'(i)];
   end
endmodule

// File: rtl/wb_write_queue.sv
// wb_write_queue: two-producer writeback queue driving the register file write port.
// WB_BYPASS_EN enables the decode bypass lookup (hit/fwd); otherwise those outputs are 0.
module wb_write_queue
   import cpu_types_pkg::*;
#(
   parameter int DEPTH = WB_DEPTH_DEFAULT
) (
   input  logic        CLK,
   input  logic        RST,
   input  logic        mem_valid,
   output logic        mem_ready,
   input  logic [4:0]  mem_sel,
   input  logic [31:0] mem_dat,
   input  logic        alu_valid,
   output logic        alu_ready,
   input  logic [4:0]  alu_sel,
   input  logic [31:0] alu_dat,
   output logic        rf_wen,
   output logic [4:0]  rf_wsel,
   output logic [31:0] rf_wdat,
   input  logic [4:0]  rsel1,
   input  logic [4:0]  rsel2,
   output logic        hit1,
   output logic        hit2,
   output logic [31:0] fwd1,
   output logic [31:0] fwd2,
   output logic        empty
);
   localparam int AW = $clog2(DEPTH);
   wb_entry_t head, mem_e, alu_e;
   wb_entry_t [DEPTH-1:0] entries;
   logic [AW:0] count;
   logic [AW+1:0] free;
   logic [1:0] push_n;
   logic pop, mem_go, alu_go;
   assign pop = count != '0;
   // free slots include the head leaving this cycle
   assign free = (AW+2)'(DEPTH) - (AW+2)'(count) + (AW+2)'(pop);
   assign mem_ready = free != '0;
   assign alu_ready = free > (AW+2)'(1) || (free == (AW+2)'(1) && !mem_valid);
   // writes to r0 complete the handshake but are dropped here
   assign mem_go = mem_valid && mem_ready && mem_sel != '0;
   assign alu_go = alu_valid && alu_ready && alu_sel != '0;
   assign push_n = {1'b0, mem_go} + {1'b0, alu_go};
   assign mem_e = '{sel: mem_sel, dat: mem_dat};
   assign alu_e = '{sel: alu_sel, dat: alu_dat};
   wb_fifo #(.DEPTH(DEPTH)) u_fifo (
      .clk(CLK),
      .rst(RST),
      .push_n(push_n),
      .push0(mem_go ? mem_e : alu_e),
      .push1(alu_e),
      .pop(pop),
      .head(head),
      .count(count),
      .entries(entries)
   );
   always_ff @(posedge CLK or posedge RST)
      if (RST) begin
         rf_wen <= 1'b0;
         rf_wsel <= '0;
         rf_wdat <= '0;
      end else begin
         rf_wen <= pop;
         if (pop) begin
            rf_wsel <= head.sel;
            rf_wdat <= head.dat;
         end
      end
   assign empty = count == '0 && !rf_wen;
`ifdef WB_BYPASS_EN
   // oldest candidate first so the youngest match overwrites; r0 never resides anywhere
   function automatic logic [32:0] lookup(input logic [4:0] sel);
      logic [32:0] r;
      r = {rf_wen && rf_wsel == sel, rf_wdat};
      for (int i = 0; i < DEPTH; i++)
         if ((AW+1)'(i) < count && entries[i].sel == sel) r = {1'b1, entries[i].dat};
      return r[32] ? r : '0;
   endfunction
   always_comb {hit1, fwd1} = lookup(rsel1);
   always_comb {hit2, fwd2} = lookup(rsel2);
`else
   logic unused_bypass;
   assign {hit1, fwd1, hit2, fwd2} = '0;
   assign unused_bypass = ^{rsel1, rsel2, entries};
`endif
endmodule

// File: tb/tb_wb_write_queue.sv
// tb_wb_write_queue: directed self-checking bench for wb_write_queue (either WB_BYPASS_EN build).
module tb_wb_write_queue;
`ifdef WB_BYPASS_EN
   localparam bit BYP = 1'b1;
`else
   localparam bit BYP = 1'b0;
`endif
   logic CLK = 1'b0, RST = 1'b1;
   logic mem_valid = 0, alu_valid = 0;
   logic mem_ready, alu_ready, rf_wen, hit1, hit2, empty;
   logic [4:0] mem_sel = 0, alu_sel = 0, rsel1 = 0, rsel2 = 0, rf_wsel;
   logic [31:0] mem_dat = 0, alu_dat = 0, rf_wdat, fwd1, fwd2;
   int checks = 0, passed = 0;

   wb_write_queue #(.DEPTH(4)) dut (
      .CLK(CLK), .RST(RST),
      .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_sel(mem_sel), .mem_dat(mem_dat),
      .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_sel(alu_sel), .alu_dat(alu_dat),
      .rf_wen(rf_wen), .rf_wsel(rf_wsel), .rf_wdat(rf_wdat),
      .rsel1(rsel1), .rsel2(rsel2), .hit1(hit1), .hit2(hit2), .fwd1(fwd1), .fwd2(fwd2),
      .empty(empty)
   );

   always #5 CLK = ~CLK;

   task automatic tick;
      @(posedge CLK);
      #1;
   endtask

   task automatic test_reset;
      #7;
      RST = 1'b0;
      #1;
      checks++; if (rf_wen !== 1'b0) $display("FAIL reset_wen got %b want 0", rf_wen); else passed++;
      checks++; if (rf_wsel !== 5'd0 || rf_wdat !== 32'd0) $display("FAIL reset_wdat got %h/%h want 0/0", rf_wsel, rf_wdat); else passed++;
      checks++; if ({mem_ready, alu_ready} !== 2'b11) $display("FAIL reset_ready got %b want 11", {mem_ready, alu_ready}); else passed++;
      checks++; if ({hit1, hit2, fwd1, fwd2} !== 66'd0) $display("FAIL reset_bypass got %b%b %h %h want 0", hit1, hit2, fwd1, fwd2); else passed++;
      checks++; if (empty !== 1'b1) $display("FAIL reset_empty got %b want 1", empty); else passed++;
   endtask

   task automatic test_single;
      tick;
      alu_valid = 1; alu_sel = 5; alu_dat = 32'hDEADBEEF; rsel1 = 5;
      #1;
      checks++; if (alu_ready !== 1'b1) $display("FAIL single_ready got %b want 1", alu_ready); else passed++;
      tick;
      alu_valid = 0;
      #1;
      checks++; if (rf_wen !== 1'b0 || empty !== 1'b0) $display("FAIL single_queued wen/empty got %b/%b want 0/0", rf_wen, empty); else passed++;
      checks++; if (hit1 !== BYP || fwd1 !== (BYP ? 32'hDEADBEEF : 32'h0)) $display("FAIL single_fwdq got %b %h want %b", hit1, fwd1, BYP); else passed++;
      tick;
      checks++; if ({rf_wen, rf_wsel, rf_wdat} !== {1'b1, 5'd5, 32'hDEADBEEF}) $display("FAIL single_write got %b %0d %h want 1 5 deadbeef", rf_wen, rf_wsel, rf_wdat); else passed++;
      checks++; if (hit1 !== BYP) $display("FAIL single_fwdout got %b want %b", hit1, BYP); else passed++;
      tick;
      checks++; if (rf_wen !== 1'b0 || empty !== 1'b1 || rf_wsel !== 5'd5) $display("FAIL single_done wen/empty/wsel got %b/%b/%0d want 0/1/5", rf_wen, empty, rf_wsel); else passed++;
      rsel1 = 0;
   endtask

   task automatic test_same_cycle;
      mem_valid = 1; mem_sel = 3; mem_dat = 32'h11;
      alu_valid = 1; alu_sel = 3; alu_dat = 32'h22;
      rsel1 = 3; rsel2 = 3;
      #1;
      checks++; if ({mem_ready, alu_ready} !== 2'b11) $display("FAIL same_ready got %b want 11", {mem_ready, alu_ready}); else passed++;
      tick;
      mem_valid = 0; alu_valid = 0;
      #1;
      checks++; if (hit1 !== BYP || fwd1 !== (BYP ? 32'h22 : 32'h0)) $display("FAIL same_fwd1 got %b %h want %b", hit1, fwd1, BYP); else passed++;
      checks++; if (hit2 !== BYP || fwd2 !== (BYP ? 32'h22 : 32'h0)) $display("FAIL same_fwd2 got %b %h want %b", hit2, fwd2, BYP); else passed++;
      tick;
      checks++; if ({rf_wen, rf_wsel, rf_wdat} !== {1'b1, 5'd3, 32'h11}) $display("FAIL same_first got %b %0d %h want 1 3 11", rf_wen, rf_wsel, rf_wdat); else passed++;
      checks++; if (fwd1 !== (BYP ? 32'h22 : 32'h0)) $display("FAIL same_fwd_young got %h", fwd1); else passed++;
      tick;
      checks++; if ({rf_wen, rf_wsel, rf_wdat} !== {1'b1, 5'd3, 32'h22}) $display("FAIL same_second got %b %0d %h want 1 3 22", rf_wen, rf_wsel, rf_wdat); else passed++;
      tick;
      checks++; if (rf_wen !== 1'b0 || hit1 !== 1'b0 || empty !== 1'b1) $display("FAIL same_done wen/hit/empty got %b/%b/%b want 0/0/1", rf_wen, hit1, empty); else passed++;
      rsel1 = 0; rsel2 = 0;
   endtask

   task automatic test_fill;
      int ai, w;
      logic [4:0] es;
      logic [31:0] ed;
      for (int e = 0; e < 12; e++) begin
         ai = e < 4 ? e : e - 1;
         mem_valid = e < 4; mem_sel = 5'(10 + e); mem_dat = 32'(256 + e);
         alu_valid = e < 7; alu_sel = 5'(20 + ai); alu_dat = 32'(512 + ai);
         #1;
         if (e <= 6) begin
            checks++; if ({mem_ready, alu_ready} !== {1'b1, e != 3}) $display("FAIL fill_ready cycle %0d got %b want %b", e, {mem_ready, alu_ready}, {1'b1, e != 3}); else passed++;
         end
         tick;
         w = e - 1;
         es = w < 8 ? (w % 2 == 0 ? 5'(10 + w / 2) : 5'(20 + w / 2)) : 5'(20 + w - 4);
         ed = w < 8 ? (w % 2 == 0 ? 32'(256 + w / 2) : 32'(512 + w / 2)) : 32'(512 + w - 4);
         if (e >= 1 && e <= 10) begin
            checks++; if ({rf_wen, rf_wsel, rf_wdat} !== {1'b1, es, ed}) $display("FAIL fill_write %0d got %b %0d %h want 1 %0d %h", w, rf_wen, rf_wsel, rf_wdat, es, ed); else passed++;
         end else begin
            checks++; if (rf_wen !== 1'b0) $display("FAIL fill_idle edge %0d got %b want 0", e, rf_wen); else passed++;
         end
      end
      checks++; if (empty !== 1'b1) $display("FAIL fill_empty got %b want 1", empty); else passed++;
   endtask

   task automatic test_zero;
      alu_valid = 1; alu_sel = 0; alu_dat = 32'hFFFF;
      #1;
      checks++; if (alu_ready !== 1'b1 || hit1 !== 1'b0) $display("FAIL zero_accept ready/hit got %b/%b want 1/0", alu_ready, hit1); else passed++;
      tick;
      alu_valid = 0;
      #1;
      checks++; if (empty !== 1'b1 || hit1 !== 1'b0 || hit2 !== 1'b0) $display("FAIL zero_drop empty/hit got %b/%b%b want 1/00", empty, hit1, hit2); else passed++;
      tick;
      checks++; if (rf_wen !== 1'b0 || rf_wsel !== 5'd25) $display("FAIL zero_nowrite wen/wsel got %b/%0d want 0/25", rf_wen, rf_wsel); else passed++;
   endtask

   task automatic test_reset_mid;
      mem_valid = 1; mem_sel = 7; mem_dat = 32'h71;
      alu_valid = 1; alu_sel = 8; alu_dat = 32'h81;
      tick;
      mem_sel = 9; mem_dat = 32'h91; alu_sel = 10; alu_dat = 32'hA1;
      tick;
      mem_valid = 0; alu_valid = 0; rsel1 = 9;
      RST = 1'b1;
      #1;
      checks++; if (rf_wen !== 1'b0 || empty !== 1'b1) $display("FAIL rstmid_now wen/empty got %b/%b want 0/1", rf_wen, empty); else passed++;
      checks++; if ({mem_ready, alu_ready, hit1} !== 3'b110) $display("FAIL rstmid_ready got %b want 110", {mem_ready, alu_ready, hit1}); else passed++;
      #2;
      RST = 1'b0;
      for (int k = 0; k < 3; k++) begin
         tick;
         checks++; if (rf_wen !== 1'b0 || rf_wsel !== 5'd0) $display("FAIL rstmid_after %0d wen/wsel got %b/%0d want 0/0", k, rf_wen, rf_wsel); else passed++;
      end
      checks++; if (empty !== 1'b1) $display("FAIL rstmid_empty got %b want 1", empty); else passed++;
      rsel1 = 0;
   endtask

   initial begin
      test_reset;
      test_single;
      test_same_cycle;
      test_fill;
      test_zero;
      test_reset_mid;
      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end
endmodule
